// File: rtl/iobuf_port_ctrl.sv
// Bidirectional pad controller: drives io only in TX, inserts a fixed
// high-Z turnaround on every direction change and synchronizes io into din.
module iobuf_port_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] io,
    input  logic [WIDTH-1:0] dout,
    input  logic             oe_req,
    output logic [WIDTH-1:0] din,
    output logic             din_change,
    output logic             drive_active,
    output logic             busy
);

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] din_d;

    // State and turnaround counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; oe_req is only looked at in RX/TX or when the count expires
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RX: begin
                if (oe_req) begin
                    state_d = TURN_TX;
                    cnt_d   = TURN_LOAD;
                end
            end
            TURN_TX: begin
                if (cnt_q == '0) begin
                    state_d = oe_req ? TX : RX;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TX: begin
                if (!oe_req) begin
                    state_d = TURN_RX;
                    cnt_d   = TURN_LOAD;
                end
            end
            TURN_RX: begin
                if (cnt_q == '0) begin
                    if (oe_req) begin
                        state_d = TURN_TX;
                        cnt_d   = TURN_LOAD;
                    end else begin
                        state_d = RX;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RX;
                cnt_d   = '0;
            end
        endcase
    end

    // Output data register: one clock of latency from dout to the pads
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout;
        end
    end

    // Input synchronizer, always running so TX data loops back into din
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            din_d <= '0;
        end else begin
            sync_q[0] <= io;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            din_d <= sync_q[SYNC_STAGES-1];
        end
    end

    // Single shared enable: whole bus driven only from registered TX state
    assign io           = (state_q == TX) ? dout_q : 'z;
    assign din          = sync_q[SYNC_STAGES-1];
    assign din_change   = (state_q == RX) && (din != din_d);
    assign drive_active = (state_q == TX);
    assign busy         = (state_q == TURN_TX) || (state_q == TURN_RX);

endmodule

// File: tb/tb_iobuf_port_ctrl.sv
// Scoreboard bench for iobuf_port_ctrl: directed vectors then random oe_req.
module tb_iobuf_port_ctrl;

    localparam int unsigned W    = 8;
    localparam int unsigned TURN = 2;

    typedef struct {
        int       tag;
        bit       chk;
        bit       da;
        bit       bsy;
        bit       chg;
        bit [7:0] io;
        bit [7:0] din;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] dout = '0;
    logic         oe_req = 1'b0;
    logic [W-1:0] din;
    logic         din_change;
    logic         drive_active;
    logic         busy;
    wire  [W-1:0] io;

    logic         ext_oe = 1'b1;
    logic [W-1:0] ext_val = '0;
    logic         rnd_mode = 1'b0;
    logic         ext_en;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    bit   [7:0]   chg_q[$];

    logic [W-1:0] dout_smp = '0;
    bit           prev_da = 1'b0;
    bit           prev_busy = 1'b0;
    int           rel_run = 100;
    int           busy_run = 0;

    assign ext_en = rnd_mode ? !drive_active : ext_oe;
    assign io     = ext_en ? ext_val : 'z;

    iobuf_port_ctrl #(
        .WIDTH       (W),
        .TURN_CYCLES (TURN),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .io           (io),
        .dout         (dout),
        .oe_req       (oe_req),
        .din          (din),
        .din_change   (din_change),
        .drive_active (drive_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        dout_smp <= dout;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    // One directed cycle: apply inputs, queue expected outputs for this cycle
    task automatic vec(input bit r, input bit oe, input logic [7:0] d, input bit eoe,
                       input logic [7:0] ev, input bit chk, input bit da, input bit bsy,
                       input bit chg, input logic [7:0] eio, input logic [7:0] edin);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = r;
        oe_req  = oe;
        dout    = d;
        ext_oe  = eoe;
        ext_val = ev;
        e.tag = cyc; e.chk = chk; e.da = da; e.bsy = bsy; e.chg = chg;
        e.io  = eio; e.din = edin;
        exp_q.push_back(e);
        if (chk && chg) chg_q.push_back(edin);
    endtask

    // Monitor: directed-phase scoreboard and random-phase protocol checker
    always @(negedge clk) begin
        if (!rnd_mode) begin
            if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) begin
                    check(drive_active == e.da, "drive_active", 32'(drive_active), 32'(e.da));
                    check(busy == e.bsy, "busy", 32'(busy), 32'(e.bsy));
                    check(din_change == e.chg, "din_change", 32'(din_change), 32'(e.chg));
                    check(io == e.io, "io", 32'(io), 32'(e.io));
                    check(din == e.din, "din", 32'(din), 32'(e.din));
                end
            end
            if (din_change === 1'b1) begin
                if (chg_q.size() == 0) begin
                    check(1'b0, "unexpected_din_change", 32'(din), 32'd0);
                end else begin
                    bit [7:0] want;
                    want = chg_q.pop_front();
                    check(din == want, "din_on_change", 32'(din), 32'(want));
                end
            end
        end else begin
            check(!(busy && drive_active), "busy_and_drive", 32'(busy), 32'd0);
            check(!(din_change && (busy || drive_active)), "din_change_outside_rx",
                  32'(din_change), 32'd0);
            if (drive_active)
                check(io == dout_smp, "rnd_io_driven", 32'(io), 32'(dout_smp));
            else
                check(io == 8'h00, "rnd_io_released", 32'(io), 32'h00);
            if (drive_active && !prev_da)
                check(rel_run >= int'(TURN), "gap_before_drive", 32'(rel_run), 32'(TURN));
            if (!drive_active && prev_da)
                check(busy, "turn_after_release", 32'(busy), 32'd1);
            if (!busy && prev_busy)
                check(busy_run > 0 && (busy_run % int'(TURN)) == 0, "busy_run_len",
                      32'(busy_run), 32'(TURN));
            rel_run   = drive_active ? 0 : rel_run + 1;
            busy_run  = busy ? busy_run + 1 : 0;
            prev_da   = drive_active;
            prev_busy = busy;
        end
    end

    initial begin
        // reset, then oe_req: two busy clocks before driving
        vec(1,0,8'h00,1,8'h00, 0, 0,0,0,8'h00,8'h00);
        vec(1,0,8'h00,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(0,1,8'hA5,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(0,1,8'hA5,1,8'h00, 1, 0,1,0,8'h00,8'h00);
        vec(0,1,8'hA5,1,8'h00, 1, 0,1,0,8'h00,8'h00);
        // TX: io follows dout one clock later, din loops back
        vec(0,1,8'h3C,0,8'h00, 1, 1,0,0,8'hA5,8'h00);
        vec(0,1,8'h3C,0,8'h00, 1, 1,0,0,8'h3C,8'h00);
        vec(0,0,8'h3C,0,8'h00, 1, 1,0,0,8'h3C,8'hA5);
        // release: high-Z at once, two busy clocks, then RX
        vec(0,0,8'h3C,1,8'h00, 1, 0,1,0,8'h00,8'h3C);
        vec(0,0,8'h3C,1,8'h00, 1, 0,1,0,8'h00,8'h3C);
        vec(0,0,8'h3C,1,8'h00, 1, 0,0,1,8'h00,8'h00);
        vec(0,0,8'h3C,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        // external driver steps io to 5A while receiving
        vec(0,0,8'h3C,1,8'h5A, 1, 0,0,0,8'h5A,8'h00);
        vec(0,0,8'h3C,1,8'h5A, 1, 0,0,0,8'h5A,8'h00);
        vec(0,0,8'h3C,1,8'h5A, 1, 0,0,1,8'h5A,8'h5A);
        vec(0,0,8'h3C,1,8'h5A, 1, 0,0,0,8'h5A,8'h5A);
        // one-clock oe_req pulse: turnaround only, never drives
        vec(0,1,8'hA5,1,8'h5A, 1, 0,0,0,8'h5A,8'h5A);
        vec(0,0,8'hA5,1,8'h5A, 1, 0,1,0,8'h5A,8'h5A);
        vec(0,0,8'hA5,1,8'h5A, 1, 0,1,0,8'h5A,8'h5A);
        vec(0,0,8'hA5,1,8'h5A, 1, 0,0,0,8'h5A,8'h5A);
        vec(0,0,8'hA5,1,8'h5A, 1, 0,0,0,8'h5A,8'h5A);
        // drive FF, then reset mid-TX
        vec(0,1,8'hFF,1,8'h5A, 1, 0,0,0,8'h5A,8'h5A);
        vec(0,1,8'hFF,1,8'h5A, 1, 0,1,0,8'h5A,8'h5A);
        vec(0,1,8'hFF,1,8'h5A, 1, 0,1,0,8'h5A,8'h5A);
        vec(0,1,8'hFF,0,8'h5A, 1, 1,0,0,8'hFF,8'h5A);
        vec(0,1,8'hFF,0,8'h5A, 1, 1,0,0,8'hFF,8'h5A);
        vec(1,1,8'hFF,0,8'h5A, 1, 1,0,0,8'hFF,8'hFF);
        vec(0,0,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(0,0,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(0,0,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        // reset during TURN_TX wins over oe_req
        vec(0,1,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(1,1,8'hFF,1,8'h00, 1, 0,1,0,8'h00,8'h00);
        vec(0,0,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);
        vec(0,0,8'hFF,1,8'h00, 1, 0,0,0,8'h00,8'h00);

        @(posedge clk);
        #1;
        check(exp_q.size() == 0, "exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check(chg_q.size() == 0, "chg_queue_drained", 32'(chg_q.size()), 32'd0);

        // random oe_req toggling with the protocol checker active
        ext_val  = 8'h00;
        rnd_mode = 1'b1;
        repeat (10000) begin
            @(posedge clk);
            #1;
            if ($urandom_range(3) == 0) oe_req = ~oe_req;
            dout = 8'($urandom_range(255, 1));
        end
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
